rtc_ad_sequencer: RTL
=====================

# rtc_ad_sequencer

Parametrised address/data sequencer for the multiplexed AD bus of the RTC chip. On a `start` request it walks one of three transaction scripts: power-up init table, group write, or group read. Each step is presented to the bus-timing controller as an address phase or a data phase and advances only on `bus_ack`. It adds several things the per-step selector lacked:
- internal step counting;
- start/busy/done handshake;
- command preamble and postamble;
- read-data capture;
- illegal-request reporting.

## Interface
Parameters:
- `DW`, 8: AD bus / register width.
- `NREG`, 3: bytes per group transfer.
- `NGRP`, 3: number of register groups (0 = time, 1 = date, 2 = timer).
- `INIT_LEN`, 10: entries in the init script.

Ports:
- `clk`, in, 1: single clock.
- `clr`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: request; sampled only in IDLE.
- `mode`, in, 2: 00 = INIT, 01 = WRITE, 10 = READ, 11 = illegal.
- `grp`, in, `$clog2(NGRP)`: group select for WRITE/READ.
- `wr_data`, in, `NREG*DW`: write bytes; byte i is `[i*DW +: DW]`.
- `busy`, out, 1: transaction in progress.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: valid with `done`; 1 = request rejected.
- `bus_req`, out, 1: phase request to the bus-timing controller.
- `bus_phase`, out, 1: 0 = address phase, 1 = data phase.
- `bus_wr`, out, 1: data-phase direction; 1 = write, 0 = read.
- `bus_ad_out`, out, `DW`: address or write data.
- `bus_ack`, in, 1: phase complete; one-cycle pulse.
- `bus_ad_in`, in, `DW`: read data; valid with `bus_ack` in a read data phase.
- `rd_data`, out, `NREG*DW`: captured read bytes.
- `rd_valid`, out, 1: one-cycle pulse with `done` after a successful READ.

## Operation
States: IDLE, PRE, ADDR, DATA, POST, DONE. Step index `idx` counts 0..N-1.

Accepting a request:
- In IDLE, `start`=1 latches `mode`, `grp` and `wr_data` (snapshot).
- If `mode`=11 or `grp`≥`NGRP` (the `grp` check applies to WRITE/READ only), go to DONE with `err`=1. No bus activity.

INIT:
- For `idx` 0..`INIT_LEN`-1: ADDR drives `INIT_TAB[idx].adr`, then DATA drives `INIT_TAB[idx].dat` with `bus_wr`=1.
- After the last entry, go to DONE.

WRITE:
- For `idx` 0..`NREG`-1: ADDR drives `GRP_BASE[grp]+idx`, then DATA drives wr byte `idx` with `bus_wr`=1.
- Then POST: an address-only phase driving `CMD_WR_XFER` (0xF1). Then DONE.

READ:
- PRE: an address-only phase driving `CMD_RD_LATCH` (0xF0).
- Then for `idx` 0..`NREG`-1: ADDR drives `GRP_BASE[grp]+idx`, then DATA with `bus_wr`=0.
- On `bus_ack` in DATA, capture `bus_ad_in` into `rd_data` byte `idx`.
- After the last byte, go to DONE.

DONE:
- `done`=1 for one cycle. `rd_valid`=1 only for a successful READ.
- Return to IDLE.

Data retention:
- `rd_data` is updated only by READ captures.
- It holds its value across INIT, WRITE and rejected requests.

## Timing
- Reset (`clr`=0 at a `clk` edge): state IDLE, `idx`=0. All outputs 0, including `rd_data`. Reset mid-transaction aborts it on that edge with no `done`.
- `busy`=1 from the cycle after `start` acceptance through the DONE cycle inclusive.
- `bus_req`=1 in PRE, ADDR, DATA and POST.
- While `bus_req`=1 and `bus_ack`=0, `bus_phase`, `bus_wr` and `bus_ad_out` are held stable.
- `bus_ack` sampled at an edge advances the state on that edge. The next phase is presented in the following cycle; no idle cycle is inserted between phases.
- `bus_ack` while `bus_req`=0 is ignored.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` in the DONE cycle is ignored. The earliest restart is the IDLE cycle after DONE.
- With a zero-wait-state controller (ack every request cycle), the cycles from acceptance to `done`:
  - INIT: 2·`INIT_LEN`+1.
  - WRITE: 2·`NREG`+2.
  - READ: 2·`NREG`+2.
  - Rejected request: 1.
- Address arithmetic: `GRP_BASE[grp]+idx` is computed modulo 2^`DW`. Wrap is allowed and is not flagged.

## Structure
- Package `rtc_ad_pkg` holds:
  - the state enum;
  - the mode encodings;
  - `CMD_RD_LATCH` and `CMD_WR_XFER`;
  - `GRP_BASE` = {0x21, 0x24, 0x41};
  - the `INIT_TAB` struct array of adr/dat pairs, default contents (02,10) (02,00) (20,00) (21,00) (22,00) (23,0C) (24,01) (25,04) (26,11) (27,01).
- One sub-module, `rtc_ad_step_mux`: combinational, mapping (state, mode, `grp`, `idx`, snapshot) to (`bus_phase`, `bus_wr`, `bus_ad_out`).
- The FSM, `idx` counter and capture registers live in `rtc_ad_sequencer`.

## Test plan
- Reset, then INIT `start` with ack every cycle: 20 phases alternate address/data, matching `INIT_TAB`; `done` at cycle 21; `err`=0; `rd_valid`=0.
- WRITE, `grp`=0, `wr_data`={0x12,0x34,0x56} (byte 2..0), ack every cycle: bus sees A21/D56, A22/D34, A23/D12, then address-only F1; `done` at cycle 8.
- READ, `grp`=1, random 0–3 cycle ack delays, `bus_ad_in` 0x07, 0x05, 0x17: F0 first, then addresses 24, 25, 26 with outputs stable during waits; `rd_data`=0x170507; `rd_valid` and `done` coincide.
- `mode`=11, or READ with `grp`=3: `done`=`err`=1 one cycle after `start`; `bus_req` stays 0; `rd_data` unchanged.
- `start` pulsed mid-WRITE and in the DONE cycle, plus a spurious `bus_ack` in IDLE: no new transaction and no state change.
- `clr`=0 during the DATA phase of a READ: next cycle all outputs 0 and state IDLE; a following INIT completes normally.

Source files
------------

// File: rtl/rtc_ad_pkg.sv
// ---- rtc_ad_pkg: shared types, command codes and scripts for the RTC AD sequencer ----
// ---- Rev 1.0 ----
`default_nettype none

package rtc_ad_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_POST = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] MODE_INIT    = 2'b00;
  localparam logic [1:0] MODE_WRITE   = 2'b01;
  localparam logic [1:0] MODE_READ    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [7:0] CMD_RD_LATCH = 8'hF0;
  localparam logic [7:0] CMD_WR_XFER  = 8'hF1;

  // Group order: time, date, timer.
  localparam logic [7:0] GRP_BASE [3] = '{8'h21, 8'h24, 8'h41};

  typedef struct packed {
    logic [7:0] adr;
    logic [7:0] dat;
  } init_ent_t;

  localparam init_ent_t INIT_TAB [10] = '{
    '{8'h02, 8'h10}, '{8'h02, 8'h00}, '{8'h20, 8'h00}, '{8'h21, 8'h00},
    '{8'h22, 8'h00}, '{8'h23, 8'h0C}, '{8'h24, 8'h01}, '{8'h25, 8'h04},
    '{8'h26, 8'h11}, '{8'h27, 8'h01}
  };

endpackage

`default_nettype wire

// File: rtl/rtc_ad_step_mux.sv
// ---- rtc_ad_step_mux: maps sequencer step to AD bus phase, direction and value ----
// ---- Rev 1.0 ----
`default_nettype none

module rtc_ad_step_mux
  import rtc_ad_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 3,
  parameter int NGRP = 3,
  parameter int IW   = 4
) (
  input  state_t                    state,
  input  logic [1:0]                mode,
  input  logic [$clog2(NGRP)-1:0]   grp,
  input  logic [IW-1:0]             idx,
  input  logic [NREG*DW-1:0]        wr_data,
  output logic                      bus_phase,
  output logic                      bus_wr,
  output logic [DW-1:0]             bus_ad_out
);

  always_comb begin
    bus_phase  = 1'b0;
    bus_wr     = 1'b0;
    bus_ad_out = '0;
    case (state)
      S_PRE:  bus_ad_out = DW'(CMD_RD_LATCH);
      S_POST: bus_ad_out = DW'(CMD_WR_XFER);
      S_ADDR: begin
        if (mode == MODE_INIT) bus_ad_out = DW'(INIT_TAB[idx].adr);
        else                   bus_ad_out = DW'(GRP_BASE[grp]) + DW'(idx);
      end
      S_DATA: begin
        bus_phase = 1'b1;
        if (mode == MODE_INIT) begin
          bus_wr     = 1'b1;
          bus_ad_out = DW'(INIT_TAB[idx].dat);
        end else if (mode == MODE_WRITE) begin
          bus_wr     = 1'b1;
          bus_ad_out = wr_data[idx*DW +: DW];
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rtc_ad_sequencer.sv
// ---- rtc_ad_sequencer: init/write/read script walker for the RTC multiplexed AD bus ----
// ---- Rev 1.0 ----
`default_nettype none

module rtc_ad_sequencer
  import rtc_ad_pkg::*;
#(
  parameter int DW       = 8,
  parameter int NREG     = 3,
  parameter int NGRP     = 3,
  parameter int INIT_LEN = 10
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [$clog2(NGRP)-1:0]  grp,
  input  logic [NREG*DW-1:0]       wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     bus_req,
  output logic                     bus_phase,
  output logic                     bus_wr,
  output logic [DW-1:0]            bus_ad_out,
  input  logic                     bus_ack,
  input  logic [DW-1:0]            bus_ad_in,
  output logic [NREG*DW-1:0]       rd_data,
  output logic                     rd_valid
);

  localparam int MAXN = (INIT_LEN > NREG) ? INIT_LEN : NREG;
  localparam int IW   = $clog2(MAXN);
  localparam int GW   = $clog2(NGRP);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_LEN - 1);
  localparam logic [IW-1:0] REG_LAST  = IW'(NREG - 1);
  localparam logic [GW:0]   NGRP_W    = NGRP[GW:0];

  state_t                state, nxt_state;
  logic [IW-1:0]         idx, nxt_idx;
  logic [1:0]            mode_q;
  logic [GW-1:0]         grp_q;
  logic [NREG*DW-1:0]    wr_q;
  logic                  reject;
  logic [IW-1:0]         last_idx;

  assign reject   = (mode == MODE_ILLEGAL) ||
                    ((mode != MODE_INIT) && ({1'b0, grp} >= NGRP_W));
  assign last_idx = (mode_q == MODE_INIT) ? INIT_LAST : REG_LAST;

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_idx = '0;
          if (reject)                 nxt_state = S_DONE;
          else if (mode == MODE_READ) nxt_state = S_PRE;
          else                        nxt_state = S_ADDR;
        end
      end
      S_PRE:  if (bus_ack) nxt_state = S_ADDR;
      S_ADDR: if (bus_ack) nxt_state = S_DATA;
      S_DATA: begin
        if (bus_ack) begin
          if (idx == last_idx) begin
            nxt_idx   = '0;
            nxt_state = (mode_q == MODE_WRITE) ? S_POST : S_DONE;
          end else begin
            nxt_idx   = idx + 1'b1;
            nxt_state = S_ADDR;
          end
        end
      end
      S_POST: if (bus_ack) nxt_state = S_DONE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= S_IDLE;
      idx      <= '0;
      mode_q   <= '0;
      grp_q    <= '0;
      wr_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bus_req  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= nxt_state;
      idx      <= nxt_idx;
      busy     <= (nxt_state != S_IDLE);
      bus_req  <= (nxt_state == S_PRE) || (nxt_state == S_ADDR) ||
                  (nxt_state == S_DATA) || (nxt_state == S_POST);
      done     <= (nxt_state == S_DONE);
      err      <= (state == S_IDLE) && (nxt_state == S_DONE);
      rd_valid <= (state == S_DATA) && (nxt_state == S_DONE) && (mode_q == MODE_READ);
      if ((state == S_IDLE) && start) begin
        mode_q <= mode;
        grp_q  <= grp;
        wr_q   <= wr_data;
      end
      if ((state == S_DATA) && bus_ack && (mode_q == MODE_READ))
        rd_data[idx*DW +: DW] <= bus_ad_in;
    end
  end

  rtc_ad_step_mux #(
    .DW   (DW),
    .NREG (NREG),
    .NGRP (NGRP),
    .IW   (IW)
  ) u_step_mux (
    .state      (state),
    .mode       (mode_q),
    .grp        (grp_q),
    .idx        (idx),
    .wr_data    (wr_q),
    .bus_phase  (bus_phase),
    .bus_wr     (bus_wr),
    .bus_ad_out (bus_ad_out)
  );

endmodule

`default_nettype wire
